ibis_axi4_master: RTL

- AXI4-lite initiator, the counterpart of the Ibis AXI4 responder.
- Takes single-beat read/write commands from a simple valid/ready command port, drives the AW/W/B/AR/R channels, and returns each completion on a response port.
- Used for loopback verification of the responder and as the bus-side engine for on-chip control sequencers.
- One outstanding transaction at a time.

---
 rtl/ibis_pkg.sv | 34 +++
 rtl/ibis_watchdog.sv | 42 ++++
 rtl/ibis_axi4_master.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ibis_pkg.sv
// Shared types and constants for the Ibis AXI4-lite master.
package ibis_pkg;

  localparam int unsigned IBIS_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IBIS_RESP_OKAY   = 2'b00,
    IBIS_RESP_EXOKAY = 2'b01,
    IBIS_RESP_SLVERR = 2'b10,
    IBIS_RESP_DECERR = 2'b11
  } ibis_axi_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_DONE
  } ibis_mst_state_t;

  // Completion payload held in DONE until the consumer takes it.
  typedef struct packed {
    logic                       write;
    logic [IBIS_DATA_WIDTH-1:0] rdata;
    ibis_axi_resp_t             resp;
  } ibis_rsp_t;

  // States in which the master is waiting on the bus.
  function automatic logic is_bus_state(ibis_mst_state_t s);
    return (s == ST_WR_REQ) || (s == ST_WR_RESP) || (s == ST_RD_REQ) || (s == ST_RD_RESP);
  endfunction

endpackage

// File: rtl/ibis_watchdog.sv
// Cycle counter for bus-wait states with a sticky timeout flag.
// Only instantiated when IBIS_AXI4_MASTER_TIMEOUT_EN is defined.
module ibis_watchdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic restart_i,
  output logic timeout_o
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
  logic             timeout_q, timeout_d;

  // Flag fires on the LIMIT-th waiting cycle, even if the state is left on that edge.
  always_comb begin
    cnt_inc_c = cnt_q + CNT_W'(1);
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (active_i && (cnt_q != CNT_W'(LIMIT))) begin
      cnt_d = cnt_inc_c;
      if (cnt_inc_c == CNT_W'(LIMIT)) timeout_d = 1'b1;
    end
    if (restart_i) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/ibis_axi4_master.sv
// AXI4-lite initiator: one single-beat command in flight, completion on a response port.
// Optional watchdog enabled by defining IBIS_AXI4_MASTER_TIMEOUT_EN.
module ibis_axi4_master
  import ibis_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = IBIS_DATA_WIDTH
`ifdef IBIS_AXI4_MASTER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  enable,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [3:0]            wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
`ifdef IBIS_AXI4_MASTER_TIMEOUT_EN
  ,
  output logic                  timeout
`endif
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;

  ibis_mst_state_t state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic            bready_q, bready_d, rready_q, rready_d, rsp_valid_q, rsp_valid_d;
  ibis_rsp_t       rsp_q, rsp_d;
  logic            cmd_ready_c, aw_done_c, w_done_c;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    cmd_ready_c = 1'b0;
    aw_done_c   = 1'b0;
    w_done_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_c = enable & ~areset;
        if (cmd_ready_c && cmd_valid) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          rsp_d.write = cmd_write;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_REQ;
          end
        end
      end
      // AW and W retire independently; a channel already done counts as done.
      ST_WR_REQ: begin
        aw_done_c = ~awvalid_q | awready;
        w_done_c  = ~wvalid_q | wready;
        if (awready) awvalid_d = 1'b0;
        if (wready)  wvalid_d  = 1'b0;
        if (aw_done_c && w_done_c) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (bvalid) begin
          bready_d    = 1'b0;
          rsp_d.rdata = '0;
          rsp_d.resp  = ibis_axi_resp_t'(bresp);
          rsp_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_RD_REQ: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        if (rvalid) begin
          rready_d    = 1'b0;
          rsp_d.rdata = IBIS_DATA_WIDTH'(rdata);
          rsp_d.resp  = ibis_axi_resp_t'(rresp);
          rsp_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        arvalid_d   = 1'b0;
        bready_d    = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign cmd_ready = cmd_ready_c;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_q.write;
  assign rsp_rdata = DW'(rsp_q.rdata);
  assign rsp_resp  = rsp_q.resp;
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = 4'hF;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;

`ifdef IBIS_AXI4_MASTER_TIMEOUT_EN
  ibis_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (aclk),
    .rst_i    (areset),
    .active_i (is_bus_state(state_q)),
    .restart_i(state_d != state_q),
    .timeout_o(timeout)
  );
`endif

endmodule
